// File: rtl/seg_decoder_mux_if.sv
// Bus between a seven-segment display driver and the segment decoder.
//   segments    : active-low segment bus, bit6=a .. bit0=g
//   anodes      : active-low digit enables, bit i selects digit i
//   digits      : recovered hex values, digit i in [4i+3:4i]
//   digit_valid : digit i holds a committed legal value
//   update      : one-cycle pulse on each legal commit
//   upd_idx     : index of the last legal commit, held between pulses
//   pattern_err : one-cycle pulse on each illegal-pattern commit
//   err_count   : saturating count of illegal commits
// master = display side (drives segments/anodes), slave = decoder.
interface seg_decoder_mux_if #(
    parameter int NUM_DIGITS = 2
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [6:0]              segments;
    logic [NUM_DIGITS-1:0]   anodes;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    update;
    logic [IDX_W-1:0]        upd_idx;
    logic                    pattern_err;
    logic [7:0]              err_count;

    modport master (
        output segments, anodes,
        input  digits, digit_valid, update, upd_idx, pattern_err, err_count
    );

    modport slave (
        input  segments, anodes,
        output digits, digit_valid, update, upd_idx, pattern_err, err_count
    );
endinterface

// File: rtl/seg_decoder_mux.sv
// Seven-segment decoder for a multiplexed display. Samples the segment and
// anode buses, waits for STABLE_CNT identical consecutive samples of one
// selected digit, then commits the decoded hex value for that digit.
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : seg_decoder_mux_if slave (segments/anodes in, decoded results out)
//
// state | meaning
// IDLE  | no digit selected (zero or several anodes low)
// TRACK | counting identical samples of the current run
// HELD  | run committed, waiting for the sample to change
module seg_decoder_mux #(
    parameter int NUM_DIGITS = 2,
    parameter int STABLE_CNT = 4
) (
    input logic              clk,
    input logic              reset,
    seg_decoder_mux_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] HELD  = 2'd2;

    localparam logic [1:0] KIND_LEGAL   = 2'd0;
    localparam logic [1:0] KIND_BLANK   = 2'd1;
    localparam logic [1:0] KIND_ILLEGAL = 2'd2;

    localparam logic [3:0] CNT_FULL = 4'(STABLE_CNT);
    localparam logic [3:0] CNT_LAST = 4'(STABLE_CNT - 1);

    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [1:0]              state;
    logic [3:0]              run_cnt;
    logic [6:0]              run_seg;
    logic [IDX_W-1:0]        run_idx;

    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   digit_valid_q;
    logic                    update_q;
    logic [IDX_W-1:0]        upd_idx_q;
    logic                    pattern_err_q;
    logic [7:0]              err_count_q;

    logic                    sel_valid;
    logic [IDX_W-1:0]        sel_idx;
    logic                    same_run;
    logic [1:0]              kind;
    logic [3:0]              dec_val;

    assign bus.digits      = digits_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.update      = update_q;
    assign bus.upd_idx     = upd_idx_q;
    assign bus.pattern_err = pattern_err_q;
    assign bus.err_count   = err_count_q;

    // A sample is usable only when exactly one digit is enabled.
    always_comb begin
        sel_idx   = '0;
        sel_valid = ($countones(~an_q) == 1);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) sel_idx = IDX_W'(i);
        end
    end

    assign same_run = sel_valid && (seg_q == run_seg) && (sel_idx == run_idx);

    always_comb begin
        kind    = KIND_LEGAL;
        dec_val = 4'h0;
        case (seg_q)
            7'b0000001: dec_val = 4'h0;
            7'b1001111: dec_val = 4'h1;
            7'b0010010: dec_val = 4'h2;
            7'b0000110: dec_val = 4'h3;
            7'b1001100: dec_val = 4'h4;
            7'b0100100: dec_val = 4'h5;
            7'b0100000: dec_val = 4'h6;
            7'b0001111: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0000100: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b1100000: dec_val = 4'hB;
            7'b0110001: dec_val = 4'hC;
            7'b1000010: dec_val = 4'hD;
            7'b0110000: dec_val = 4'hE;
            7'b0111000: dec_val = 4'hF;
            7'b1111111: kind = KIND_BLANK;
            default:    kind = KIND_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q         <= 7'h7F;
            an_q          <= '1;
            state         <= IDLE;
            run_cnt       <= 4'd0;
            run_seg       <= 7'h7F;
            run_idx       <= '0;
            digits_q      <= '0;
            digit_valid_q <= '0;
            update_q      <= 1'b0;
            upd_idx_q     <= '0;
            pattern_err_q <= 1'b0;
            err_count_q   <= 8'd0;
        end else begin
            seg_q         <= bus.segments;
            an_q          <= bus.anodes;
            update_q      <= 1'b0;
            pattern_err_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state   <= TRACK;
                        run_cnt <= 4'd1;
                        run_seg <= seg_q;
                        run_idx <= sel_idx;
                    end
                end
                TRACK: begin
                    if (!sel_valid) begin
                        state   <= IDLE;
                        run_cnt <= 4'd0;
                    end else if (!same_run) begin
                        run_cnt <= 4'd1;
                        run_seg <= seg_q;
                        run_idx <= sel_idx;
                    end else if (run_cnt == CNT_LAST) begin
                        // The count reaches STABLE_CNT on this edge, so the
                        // commit is registered here rather than one edge later.
                        state   <= HELD;
                        run_cnt <= CNT_FULL;
                        case (kind)
                            KIND_LEGAL: begin
                                digits_q[4*sel_idx +: 4] <= dec_val;
                                digit_valid_q[sel_idx]   <= 1'b1;
                                update_q                 <= 1'b1;
                                upd_idx_q                <= sel_idx;
                            end
                            KIND_BLANK: begin
                                digit_valid_q[sel_idx] <= 1'b0;
                            end
                            default: begin
                                digit_valid_q[sel_idx] <= 1'b0;
                                pattern_err_q          <= 1'b1;
                                if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
                            end
                        endcase
                    end else begin
                        run_cnt <= run_cnt + 4'd1;
                    end
                end
                HELD: begin
                    if (!sel_valid) begin
                        state   <= IDLE;
                        run_cnt <= 4'd0;
                    end else if (!same_run) begin
                        state   <= TRACK;
                        run_cnt <= 4'd1;
                        run_seg <= seg_q;
                        run_idx <= sel_idx;
                    end
                end
                default: begin
                    state   <= IDLE;
                    run_cnt <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: doc/seg_decoder_mux.md
SEG_DECODER_MUX -- requirements
Module: seg_decoder_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 2: number of multiplexed digits observed.
REQ-002 Parameter STABLE_CNT, default 4, legal range 2..15: consecutive identical samples required before a commit.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 segments  input  7  active-low segment bus; bit6=a through bit0=g.
REQ-006 anodes  input  NUM_DIGITS  active-low digit enables; bit i selects digit i.
REQ-007 digits  output  4*NUM_DIGITS  recovered hex values; digit i in bits [4i+3:4i].
REQ-008 digit_valid  output  NUM_DIGITS  digit i holds a committed legal value.
REQ-009 update  output  1  one-cycle pulse on each legal commit.
REQ-010 upd_idx  output  $clog2(NUM_DIGITS), min 1  index of digit committed; held between pulses.
REQ-011 pattern_err  output  1  one-cycle pulse on each illegal-pattern commit.
REQ-012 err_count  output  8  saturating count of illegal commits.

Function
REQ-013 Inputs SHALL be registered once (input stage) before any comparison or decoding.
REQ-014 A registered sample SHALL be "selected" only if exactly one anodes bit is 0; its index is the active digit.
REQ-015 Decode table SHALL map: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F.
REQ-016 Pattern 1111111 SHALL be classed "blank"; any other unlisted pattern SHALL be classed "illegal".
REQ-017 FSM states SHALL be IDLE, TRACK, HELD; reset state IDLE.
REQ-018 IDLE: selected sample -> TRACK with run counter=1; unselected -> stay IDLE.
REQ-019 TRACK: sample identical (index and pattern) to previous -> counter+1; different selected sample -> counter=1, stay TRACK; unselected -> IDLE.
REQ-020 TRACK: when counter reaches STABLE_CNT, SHALL commit and go to HELD.
REQ-021 HELD: identical sample -> stay HELD, no further commit; different selected -> TRACK with counter=1; unselected -> IDLE.
REQ-022 Legal commit: digits[idx]=decoded value, digit_valid[idx]=1, update=1, upd_idx=idx for one cycle.
REQ-023 Blank commit: digit_valid[idx]=0, digits[idx] unchanged, no update, no pattern_err.
REQ-024 Illegal commit: digit_valid[idx]=0, pattern_err=1 one cycle, err_count+1 saturating at 255.
REQ-025 Latency: pattern first present before edge k and held through edge k+STABLE_CNT-1 SHALL yield commit outputs visible after edge k+STABLE_CNT.
REQ-026 A run of any length SHALL produce exactly one commit; a run shorter than STABLE_CNT SHALL produce none.
REQ-027 Digits not being committed SHALL retain digits and digit_valid values.
REQ-028 update and pattern_err SHALL never assert in the same cycle.

Reset
REQ-029 reset SHALL force IDLE, counter=0, input stage to anodes all-1/segments all-1, digits=0, digit_valid=0, update=0, upd_idx=0, pattern_err=0, err_count=0.
REQ-030 reset asserted mid-TRACK or mid-HELD SHALL discard the run; no commit SHALL occur from pre-reset samples.

Verification (NUM_DIGITS=2, STABLE_CNT=4)
REQ-031 anodes=10, segments=0010010 for 4 edges -> digits[3:0]=2, digit_valid=01, update one cycle, upd_idx=0.
REQ-032 anodes=01, segments=0001000 for 3 edges then segments=1001111 for 4 edges -> no commit for A; digits[7:4]=1, digit_valid[1]=1, upd_idx=1.
REQ-033 anodes=10, segments=1111110 for 4 edges -> pattern_err one cycle, err_count=1, digit_valid[0]=0, no update.
REQ-034 anodes=00 or 11 for 10 edges with any segments -> FSM stays IDLE, no update, no pattern_err.
REQ-035 anodes=10, segments=0000000 held 20 edges -> exactly one update, digits[3:0]=8; then blank 1111111 for 4 edges -> digit_valid[0]=0, digits[3:0]=8.
REQ-036 3 identical samples then reset for 1 cycle then 2 more identical samples -> no update; all outputs at reset values.
